// File: rtl/divider_stream.sv
// Signed fixed-point divider, q = (a << FBITS) / b in Q(WIDTH-FBITS).FBITS.
// Radix-2 restoring division, one quotient bit per clock, with
// valid/ready streaming on both sides, per-operation rounding and
// saturation, and a pass-through tag.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and once out_valid is raised the
// result, tag and flags stay put until the edge that completes the
// transfer.
module divider_stream #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_round,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             busy
);

  localparam int ITER = WIDTH + FBITS;
  localparam int QW   = ITER + 1;
  localparam int CW   = $clog2(ITER);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;      // partial remainder, always < |b|
  logic [ITER-1:0]  qr;       // dividend shifts out the top, quotient shifts in
  logic [WIDTH-1:0] mag_b;
  logic             sign_a;
  logic             sign_b;
  logic             rnd;
  logic             sat;
  logic [TAG_W-1:0] tag;
  logic [CW-1:0]    cnt;

  // Magnitudes are WIDTH-bit unsigned so the most-negative value maps exactly
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [ITER-1:0]  dvd_init;
  logic [WIDTH-1:0] dbz_q;

  // Operand conditioning at the accept edge
  always_comb begin
    mag_a_in = in_a[WIDTH-1] ? (~in_a + WIDTH'(1)) : in_a;
    mag_b_in = in_b[WIDTH-1] ? (~in_b + WIDTH'(1)) : in_b;
    dvd_init = ITER'(mag_a_in) << FBITS;
    dbz_q    = '0;
    if (in_sat && (mag_a_in != '0)) begin
      dbz_q = in_a[WIDTH-1] ? MIN_NEG : MAX_POS;
    end
  end

  logic [WIDTH:0]   acc_sh;
  logic             acc_ge;
  logic [WIDTH-1:0] acc_nx;
  logic [ITER-1:0]  qr_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    acc_sh = {acc, qr[ITER-1]};
    acc_ge = (acc_sh >= {1'b0, mag_b});
    acc_nx = acc_ge ? (acc_sh[WIDTH-1:0] - mag_b) : acc_sh[WIDTH-1:0];
    qr_nx  = {qr[ITER-2:0], acc_ge};
  end

  logic [WIDTH:0]   rem2;
  logic             round_up;
  logic [QW-1:0]    qm;
  logic [QW-1:0]    limit;
  logic             sign_diff;
  logic             ovf;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] sat_val;

  // Rounding, range check and sign restoration for the finished quotient
  always_comb begin
    rem2      = {acc, 1'b0};
    round_up  = rnd && ((rem2 > {1'b0, mag_b}) ||
                        ((rem2 == {1'b0, mag_b}) && qr[0]));
    qm        = {1'b0, qr} + QW'(round_up);
    sign_diff = sign_a ^ sign_b;
    // A negative result may reach 2^(WIDTH-1); a positive one stops one short
    limit     = (QW'(1) << (WIDTH - 1)) - QW'(!sign_diff);
    ovf       = (qm > limit);
    q_mag     = qm[WIDTH-1:0];
    q_res     = sign_diff ? (~q_mag + WIDTH'(1)) : q_mag;
    sat_val   = sign_diff ? MIN_NEG : MAX_POS;
  end

  // Control FSM with registered handshake outputs and the datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_tag   <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
      acc       <= '0;
      qr        <= '0;
      mag_b     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      rnd       <= 1'b0;
      sat       <= 1'b0;
      tag       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_a   <= in_a[WIDTH-1];
            sign_b   <= in_b[WIDTH-1];
            mag_b    <= mag_b_in;
            tag      <= in_tag;
            rnd      <= in_round;
            sat      <= in_sat;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_b == '0) begin
              // Divide by zero skips the iteration and presents at once
              state     <= OUT;
              out_valid <= 1'b1;
              out_q     <= dbz_q;
              out_tag   <= in_tag;
              out_dbz   <= 1'b1;
              out_ovf   <= 1'b0;
            end else begin
              state <= CALC;
              acc   <= '0;
              qr    <= dvd_init;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          qr  <= qr_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          state     <= OUT;
          out_valid <= 1'b1;
          out_tag   <= tag;
          out_dbz   <= 1'b0;
          out_ovf   <= ovf;
          if (ovf) begin
            out_q <= sat ? sat_val : '0;
          end else begin
            out_q <= q_res;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_stream.sv
// Directed and randomised bench for divider_stream at default parameters.
module tb_divider_stream;

  localparam int W    = 32;
  localparam int FB   = 16;
  localparam int TW   = 4;
  localparam int ITER = W + FB;
  localparam int EW   = W + TW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_round = 1'b0;
  logic          in_sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_q;
  logic [TW-1:0] out_tag;
  logic          out_dbz;
  logic          out_ovf;
  logic          busy;

  // expected entries are {q, tag, dbz, ovf}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  divider_stream #(.WIDTH(W), .FBITS(FB), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .in_round  (in_round),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_tag   (out_tag),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Reference: exact integer division, then rounding and range rules
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                       input logic sat, output logic [31:0] q, output logic dbz,
                       output logic ovf);
    logic [31:0] ma, mb;
    logic [63:0] d, qm, r, lim;
    logic        sd;
    ma  = a[31] ? (~a + 32'd1) : a;
    mb  = b[31] ? (~b + 32'd1) : b;
    sd  = a[31] ^ b[31];
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 32'd0) begin
      dbz = 1'b1;
      q   = (!sat || a == 32'd0) ? 32'd0 : (a[31] ? 32'h80000000 : 32'h7FFFFFFF);
    end else begin
      d  = {32'd0, ma} << FB;
      qm = d / {32'd0, mb};
      r  = d % {32'd0, mb};
      if (rnd && (((r << 1) > {32'd0, mb}) || (((r << 1) == {32'd0, mb}) && qm[0])))
        qm = qm + 64'd1;
      lim = sd ? 64'h80000000 : 64'h7FFFFFFF;
      if (qm > lim) begin
        ovf = 1'b1;
        q   = sat ? (sd ? 32'h80000000 : 32'h7FFFFFFF) : 32'd0;
      end else begin
        q = sd ? (32'd0 - qm[31:0]) : qm[31:0];
      end
    end
  endtask

  // Drive one request from a negedge; returns at the negedge after the accept edge
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                          input logic rnd, input logic sat);
    int w;
    w        = 0;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    in_round = rnd;
    in_sat   = sat;
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_tag   = 4'($urandom);
    in_round = 1'($urandom);
    in_sat   = 1'($urandom);
  endtask

  // n = edges after the accept edge until out_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_out(input string name);
    logic [EW-1:0] e;
    chk({name, " queue"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({name, " q"},   64'(out_q),   64'(e[EW-1:TW+2]));
      chk({name, " tag"}, 64'(out_tag), 64'(e[TW+1:2]));
      chk({name, " dbz"}, 64'(out_dbz), 64'(e[1]));
      chk({name, " ovf"}, 64'(out_ovf), 64'(e[0]));
    end
  endtask

  // Full operation with out_ready held high
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic rnd, input logic sat,
                        input logic [31:0] eq, input logic edbz, input logic eovf);
    int n;
    int lat;
    lat = (b == 32'd0) ? 0 : ITER + 1;
    exp_q.push_back({eq, t, edbz, eovf});
    drive_op(a, b, t, rnd, sat);
    wait_valid(n);
    chk({name, " latency"}, 64'(n), 64'(lat));
    check_out(name);
    @(negedge clk);
    chk({name, " drain valid"}, 64'(out_valid), 64'd0);
    chk({name, " drain ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int            n;
    int            seen;
    logic [EW-1:0] e;
    logic [31:0]   ra, rb, rq;
    logic          rr, rs, rd, ro;
    logic [3:0]    rt;

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_q", 64'(out_q), 64'd0);
    chk("rst out_tag", 64'(out_tag), 64'd0);
    chk("rst flags", 64'({out_dbz, out_ovf}), 64'd0);
    rst_n = 1'b1;

    // directed
    run_op("basic",        32'h00030000, 32'h00020000, 4'd5,  1'b0, 1'b0, 32'h00018000, 1'b0, 1'b0);
    run_op("round trunc",  32'h00020000, 32'h00030000, 4'd1,  1'b0, 1'b0, 32'h0000AAAA, 1'b0, 1'b0);
    run_op("round up",     32'h00020000, 32'h00030000, 4'd2,  1'b1, 1'b0, 32'h0000AAAB, 1'b0, 1'b0);
    run_op("round neg",    32'hFFFE0000, 32'h00030000, 4'd3,  1'b1, 1'b0, 32'hFFFF5555, 1'b0, 1'b0);
    run_op("tie even 0",   32'h00000001, 32'h00020000, 4'd4,  1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0);
    run_op("tie even 1",   32'h00000003, 32'h00020000, 4'd6,  1'b1, 1'b0, 32'h00000002, 1'b0, 1'b0);
    run_op("tie trunc",    32'h00000003, 32'h00020000, 4'd7,  1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    run_op("minneg ok",    32'h80000000, 32'h00010000, 4'd8,  1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0);
    run_op("minneg sat",   32'h80000000, 32'hFFFF0000, 4'd9,  1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("minneg nosat", 32'h80000000, 32'hFFFF0000, 4'd10, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1);
    run_op("maxpos sat",   32'h7FFFFFFF, 32'h00000001, 4'd11, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("neg sat",      32'h7FFFFFFF, 32'hFFFFFFFF, 4'd12, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
    run_op("dbz pos",      32'h00050000, 32'h00000000, 4'd13, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_op("dbz neg",      32'hFFFB0000, 32'h00000000, 4'd14, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b0);
    run_op("dbz zero",     32'h00000000, 32'h00000000, 4'd15, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    run_op("dbz nosat",    32'h00050000, 32'h00000000, 4'd0,  1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("after dbz",    32'h00030000, 32'h00020000, 4'd5,  1'b1, 1'b1, 32'h00018000, 1'b0, 1'b0);

    // randomised against the reference model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom >> $urandom_range(0, 16);
      rb = $urandom >> $urandom_range(4, 24);
      if ($urandom_range(0, 1) == 1) ra = 32'd0 - ra;
      if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
      rr = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rt = 4'($urandom_range(0, 15));
      model(ra, rb, rr, rs, rq, rd, ro);
      run_op("random", ra, rb, rt, rr, rs, rq, rd, ro);
    end

    // backpressure with a pending request
    out_ready = 1'b0;
    exp_q.push_back({32'h0000AAAB, 4'hA, 1'b0, 1'b0});
    drive_op(32'h00020000, 32'h00030000, 4'hA, 1'b1, 1'b0);
    wait_valid(n);
    chk("bp latency", 64'(n), 64'(ITER + 1));
    e        = exp_q[0];
    in_a     = 32'hFFFE0000;
    in_b     = 32'h00030000;
    in_tag   = 4'hB;
    in_round = 1'b1;
    in_sat   = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back({32'hFFFF5555, 4'hB, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp hold valid", 64'(out_valid), 64'd1);
      chk("bp hold q", 64'(out_q), 64'(e[EW-1:TW+2]));
      chk("bp hold tag", 64'(out_tag), 64'(e[TW+1:2]));
      chk("bp hold flags", 64'({out_dbz, out_ovf}), 64'(e[1:0]));
      chk("bp hold in_ready", 64'(in_ready), 64'd0);
    end
    check_out("bp first");
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp pending accepted", 64'(busy), 64'd1);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    wait_valid(n);
    chk("bp pending latency", 64'(n), 64'(ITER + 1));
    check_out("bp pending");
    @(negedge clk);
    chk("bp drain valid", 64'(out_valid), 64'd0);

    // reset in the middle of CALC
    drive_op(32'h00030000, 32'h00020000, 4'd3, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("midrst busy before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no result", 64'(seen), 64'd0);
    run_op("post reset", 32'h00030000, 32'h00020000, 4'd5, 1'b0, 1'b0, 32'h00018000, 1'b0, 1'b0);

    chk("queue empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
